// File: rtl/vga_timing.sv
// 640x480@60 VGA raster generator with a registered, mutually aligned DAC pin stage.
// Define VGA_CLK_DIV_EN when clk is 50 MHz; the pixel enable then runs at half rate.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    R_in,
  input  logic [7:0]    G_in,
  input  logic [7:0]    B_in,
  output logic [CW-1:0] h_counter,
  output logic [CW-1:0] v_counter,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N,
  output logic          VGA_CLK,
  output logic          frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic pe;

`ifdef VGA_CLK_DIV_EN
  logic phase_q;
  logic vga_clk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= 1'b0;
      vga_clk_q <= 1'b0;
    end else begin
      phase_q   <= ~phase_q;
      vga_clk_q <= phase_q;
    end
  end

  assign pe      = phase_q;
  assign VGA_CLK = vga_clk_q;
`else
  assign pe      = 1'b1;
  assign VGA_CLK = ~clk;
`endif

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          active;
  logic          hs_c;
  logic          vs_c;
  logic          frame_end;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pe) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
      end else begin
        h_d = h_q + ONE;
      end
    end
  end

  assign active    = (h_q < H_VIS) && (v_q < V_VIS);
  assign hs_c      = !((h_q >= HS_START) && (h_q <= HS_END));
  assign vs_c      = !((v_q >= VS_START) && (v_q <= VS_END));
  assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);

  logic       hs_q, vs_q, blank_n_q, frame_tick_q;
  logic [7:0] r_q, g_q, b_q;

  // Pixel pins capture the colour of the position the counters are leaving,
  // so sync, blank and RGB all lag the counters by the same single period.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q          <= '0;
      v_q          <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      blank_n_q    <= 1'b0;
      r_q          <= 8'h00;
      g_q          <= 8'h00;
      b_q          <= 8'h00;
      frame_tick_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      frame_tick_q <= pe && frame_end;
      if (pe) begin
        hs_q      <= hs_c;
        vs_q      <= vs_c;
        blank_n_q <= active;
        r_q       <= active ? R_in : 8'h00;
        g_q       <= active ? G_in : 8'h00;
        b_q       <= active ? B_in : 8'h00;
      end
    end
  end

  assign h_counter   = h_q;
  assign v_counter   = v_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line timing, shrunken instance for frame timing.
// The reference model derives every pin from the pixel index counted since reset.
module tb_vga_timing;

`ifdef VGA_CLK_DIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  localparam int SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 3;
  localparam int SV_A = 8,  SV_F = 2, SV_S = 2, SV_B = 3;
  localparam int S_FRAME = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] r_in = 8'h00, g_in = 8'h00, b_in = 8'h00;

  logic [9:0] a_h, a_v, b_h, b_v;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic       a_hs, a_vs, a_bn, a_sn, a_vclk, a_ft;
  logic       b_hs, b_vs, b_bn, b_sn, b_vclk, b_ft;

  vga_timing u_full (
    .clk(clk), .reset(reset), .R_in(r_in), .G_in(g_in), .B_in(b_in),
    .h_counter(a_h), .v_counter(a_v), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn),
    .VGA_CLK(a_vclk), .frame_tick(a_ft)
  );

  vga_timing #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .CW(10)
  ) u_small (
    .clk(clk), .reset(reset), .R_in(r_in), .G_in(g_in), .B_in(b_in),
    .h_counter(b_h), .v_counter(b_v), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn),
    .VGA_CLK(b_vclk), .frame_tick(b_ft)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int   n = 0;
  int   k = 0;
  bit   adv = 1'b0;
  bit   fixed_rgb = 1'b1;
  logic [7:0] cap_r = 8'h00, cap_g = 8'h00, cap_b = 8'h00;

  int hs_low_cnt = 0, bn_cnt = 0, vs_low_cnt = 0;
  int hs_fall_n = -1, vs_fall_n = -1;
  int a_ft_cnt = 0, b_ft_cnt = 0;

  typedef struct {
    int         idx;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       bn;
    logic [7:0] r;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at pixel %0d", name, act, exp, n);
    end
  endtask

  task automatic check_model(
    input string tag, input int ha, input int hf, input int hsy, input int hb,
    input int va, input int vf, input int vsy, input int vb,
    input logic [9:0] h, input logic [9:0] v, input logic [7:0] r, input logic [7:0] g,
    input logic [7:0] b, input logic hs, input logic vs, input logic bn,
    input logic sn, input logic vclk, input logic ft);
    int ht, vt, ph, pv;
    logic [9:0] eh, ev;
    logic ehs, evs, ebn, eft, act;
    logic [7:0] er, eg, eb;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    if (n == 0) begin
      eh = 0; ev = 0; ehs = 1; evs = 1; ebn = 0; er = 0; eg = 0; eb = 0; eft = 0;
    end else begin
      eh  = 10'(n % ht);
      ev  = 10'((n / ht) % vt);
      ph  = (n - 1) % ht;
      pv  = ((n - 1) / ht) % vt;
      act = (ph < ha) && (pv < va);
      ehs = !((ph >= ha + hf) && (ph < ha + hf + hsy));
      evs = !((pv >= va + vf) && (pv < va + vf + vsy));
      ebn = act;
      er  = act ? cap_r : 8'h00;
      eg  = act ? cap_g : 8'h00;
      eb  = act ? cap_b : 8'h00;
      eft = adv && (n % (ht * vt) == 0);
    end
    chk({tag, "_h"}, 32'(h), 32'(eh));
    chk({tag, "_v"}, 32'(v), 32'(ev));
    chk({tag, "_hs"}, 32'(hs), 32'(ehs));
    chk({tag, "_vs"}, 32'(vs), 32'(evs));
    chk({tag, "_blank_n"}, 32'(bn), 32'(ebn));
    chk({tag, "_rgb"}, {8'h00, r, g, b}, {8'h00, er, eg, eb});
    chk({tag, "_sync_n"}, 32'(sn), 32'(0));
    chk({tag, "_vga_clk"}, 32'(vclk), (DIV == 1) ? 32'(1) : 32'(adv));
    chk({tag, "_frame_tick"}, 32'(ft), 32'(eft));
  endtask

  // driver: one clk, model update, then sample on the falling edge
  task automatic tick(input bit rst);
    reset = rst;
    if (fixed_rgb) begin
      r_in = 8'hFF; g_in = 8'h80; b_in = 8'h01;
    end else begin
      r_in = 8'($urandom_range(0, 255));
      g_in = 8'($urandom_range(0, 255));
      b_in = 8'($urandom_range(0, 255));
    end
    @(posedge clk);
    if (rst) begin
      n = 0; k = 0; adv = 1'b0;
    end else begin
      k++;
      adv = (k % DIV == 0);
      if (adv) begin
        n++;
        cap_r = r_in; cap_g = g_in; cap_b = b_in;
      end
    end
    @(negedge clk);
    check_model("full", 640, 16, 96, 48, 480, 10, 2, 33,
                a_h, a_v, a_r, a_g, a_b, a_hs, a_vs, a_bn, a_sn, a_vclk, a_ft);
    check_model("small", SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B,
                b_h, b_v, b_r, b_g, b_b, b_hs, b_vs, b_bn, b_sn, b_vclk, b_ft);
    if (a_ft) a_ft_cnt++;
    if (b_ft) b_ft_cnt++;
    if (adv && n >= 1 && n <= 800) begin
      if (!a_hs) hs_low_cnt++;
      if (a_bn) bn_cnt++;
      if (!a_hs && hs_fall_n < 0) hs_fall_n = n;
    end
    if (adv && n >= 1 && n <= S_FRAME && !b_vs) begin
      vs_low_cnt++;
      if (vs_fall_n < 0) vs_fall_n = n;
    end
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (n < target && guard < 20000) begin
      tick(1'b0);
      guard++;
    end
    chk("reach_pixel", 32'(n), 32'(target));
  endtask

  initial begin
    tbl[0]  = '{1,   10'd1,   10'd0, 1'b1, 1'b1, 8'hFF};
    tbl[1]  = '{639, 10'd639, 10'd0, 1'b1, 1'b1, 8'hFF};
    tbl[2]  = '{640, 10'd640, 10'd0, 1'b1, 1'b1, 8'hFF};
    tbl[3]  = '{641, 10'd641, 10'd0, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{656, 10'd656, 10'd0, 1'b1, 1'b0, 8'h00};
    tbl[5]  = '{657, 10'd657, 10'd0, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{752, 10'd752, 10'd0, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{753, 10'd753, 10'd0, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{799, 10'd799, 10'd0, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{800, 10'd0,   10'd1, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{801, 10'd1,   10'd1, 1'b1, 1'b1, 8'hFF};

    for (int i = 0; i < 3; i++) tick(1'b1);
    chk("reset_h", 32'(a_h), 32'(0));
    chk("reset_hs_vs", {30'd0, a_hs, a_vs}, 32'(3));
    chk("reset_blank_rgb", {7'd0, a_bn, a_r, a_g, a_b}, 32'(0));

    fixed_rgb = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_to(tbl[i].idx);
      chk("tbl_h", 32'(a_h), 32'(tbl[i].h));
      chk("tbl_v", 32'(a_v), 32'(tbl[i].v));
      chk("tbl_hs", 32'(a_hs), 32'(tbl[i].hs));
      chk("tbl_blank_n", 32'(a_bn), 32'(tbl[i].bn));
      chk("tbl_r", 32'(a_r), 32'(tbl[i].r));
    end

    fixed_rgb = 1'b0;
    run_to(3 * S_FRAME);
    chk("hs_low_periods", 32'(hs_low_cnt), 32'(96));
    chk("hs_fall_pixel", 32'(hs_fall_n), 32'(657));
    chk("blank_high_periods", 32'(bn_cnt), 32'(640));
    chk("vs_low_periods", 32'(vs_low_cnt), 32'(2 * 25));
    chk("vs_fall_pixel", 32'(vs_fall_n), 32'(10 * 25 + 1));
    chk("small_frame_ticks", 32'(b_ft_cnt), 32'(3));
    chk("full_no_tick_after_reset", 32'(a_ft_cnt), 32'(0));

    // reset in the middle of hsync and vsync of the small raster
    fixed_rgb = 1'b1;
    run_to(3 * S_FRAME + 11 * 25 + 20);
    chk("mid_pos", {22'd0, b_h[4:0], b_v[4:0]}, {22'd0, 5'd20, 5'd11});
    chk("mid_syncs_low", {30'd0, b_hs, b_vs}, 32'(0));
    tick(1'b1);
    chk("abort_syncs_high", {30'd0, b_hs, b_vs}, 32'(3));
    chk("abort_counters", {12'd0, b_h, b_v}, 32'(0));
    b_ft_cnt = 0;
    run_to(S_FRAME + 30);
    chk("restart_frame_ticks", 32'(b_ft_cnt), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
